// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the unified-cache arbiter.
package cache_arbiter_pkg;

    localparam int WORD_BITWIDTH = 32;
    localparam int STRB_BITWIDTH = 4;

    typedef enum logic [1:0] {
        Idle,
        Lookup,
        Access
    } state_e;

    typedef enum logic {
        PortInstr,
        PortData
    } port_e;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Winner selection between instruction and data ports; purely combinational.
// Latency: none. Ports masked by their eligibility bit are never granted.
// CACHE_ARBITER_ROUND_ROBIN_EN: alternate on collisions, else data port wins.
module cache_arbiter_grant
    import cache_arbiter_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  logic  i_elig,
    input  logic  d_elig,
    input  port_e last_grant,
    output logic  gnt_vld,
    output port_e gnt_port
);

    logic i_cand;
    logic d_cand;

    assign i_cand  = i_req & i_elig;
    assign d_cand  = d_req & d_elig;
    assign gnt_vld = i_cand | d_cand;

    always_comb begin
        gnt_port = PortData;
        if (i_cand && d_cand) begin
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
            gnt_port = (last_grant == PortData) ? PortInstr : PortData;
`else
            gnt_port = PortData;
`endif
        end else if (i_cand) begin
            gnt_port = PortInstr;
        end
    end

`ifndef CACHE_ARBITER_ROUND_ROBIN_EN
    // Fixed priority has no use for history; keep the port for a uniform interface.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == PortData);
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single-port cache between instruction fetch and data load/store.
// Latency: req -> done is LookupCycles + 2 edges on a hit; one access in flight.
// Backpressure: requests are held by the core; cache_busy stalls with outputs frozen.
// Build option CACHE_ARBITER_ROUND_ROBIN_EN selects round-robin collision handling.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LookupCycles   = 1,
    parameter int WatchdogCycles = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [WORD_BITWIDTH-1:0] i_addr,
    output logic                     i_done,
    output logic [WORD_BITWIDTH-1:0] i_rdata,
    input  logic                     d_req,
    input  logic [WORD_BITWIDTH-1:0] d_addr,
    input  logic [WORD_BITWIDTH-1:0] d_wdata,
    input  logic [STRB_BITWIDTH-1:0] d_wstrb,
    output logic                     d_done,
    output logic [WORD_BITWIDTH-1:0] d_rdata,
    output logic                     cache_enable,
    output logic [WORD_BITWIDTH-1:0] cache_address,
    output logic [WORD_BITWIDTH-1:0] cache_data_in,
    output logic [STRB_BITWIDTH-1:0] cache_write_enable,
    input  logic [WORD_BITWIDTH-1:0] cache_data_out,
    input  logic                     cache_data_out_ready,
    input  logic                     cache_busy,
    output logic                     err
);

    localparam logic [15:0] LOOKUP_LOAD = 16'(LookupCycles);
    localparam logic [31:0] WD_LIMIT    = 32'(WatchdogCycles);

    state_e state_q, state_d;
    port_e  owner_q, owner_d;
    port_e  last_grant_q, last_grant_d;
    port_e  gnt_port;
    logic   gnt_vld;

    logic [15:0] lookup_q, lookup_d;
    logic [31:0] wd_q, wd_d;

    logic                     i_done_d, d_done_d, enable_d, err_d;
    logic [WORD_BITWIDTH-1:0] i_rdata_d, d_rdata_d, address_d, data_in_d;
    logic [STRB_BITWIDTH-1:0] write_enable_d;

    // A port whose done is high this cycle still shows the old request; mask it.
    cache_arbiter_grant u_grant (
        .i_req      (i_req),
        .d_req      (d_req),
        .i_elig     (~i_done),
        .d_elig     (~d_done),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt_port   (gnt_port)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        lookup_d       = lookup_q;
        wd_d           = wd_q;
        i_done_d       = 1'b0;
        d_done_d       = 1'b0;
        i_rdata_d      = i_rdata;
        d_rdata_d      = d_rdata;
        enable_d       = cache_enable;
        address_d      = cache_address;
        data_in_d      = cache_data_in;
        write_enable_d = cache_write_enable;
        err_d          = err;

        unique case (state_q)
            Idle: begin
                if (gnt_vld) begin
                    owner_d        = gnt_port;
                    last_grant_d   = gnt_port;
                    address_d      = (gnt_port == PortData) ? d_addr : i_addr;
                    data_in_d      = (gnt_port == PortData) ? d_wdata : '0;
                    write_enable_d = (gnt_port == PortData) ? d_wstrb : '0;
                    enable_d       = 1'b1;
                    lookup_d       = LOOKUP_LOAD;
                    wd_d           = '0;
                    state_d        = Lookup;
                end
            end
            Lookup: begin
                lookup_d = lookup_q - 16'd1;
                if (lookup_q <= 16'd1) begin
                    state_d = Access;
                end
            end
            Access: begin
                if (cache_busy) begin
                    if (wd_q != '1) begin
                        wd_d = wd_q + 32'd1;
                    end
                    if ((WD_LIMIT != 32'd0) && (wd_q + 32'd1 == WD_LIMIT)) begin
                        err_d = 1'b1;
                    end
                end else if (cache_write_enable != '0) begin
                    d_done_d       = 1'b1;
                    enable_d       = 1'b0;
                    write_enable_d = '0;
                    state_d        = Idle;
                end else if (cache_data_out_ready) begin
                    if (owner_q == PortData) begin
                        d_rdata_d = cache_data_out;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = cache_data_out;
                        i_done_d  = 1'b1;
                    end
                    enable_d       = 1'b0;
                    write_enable_d = '0;
                    state_d        = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= Idle;
            owner_q            <= PortInstr;
            last_grant_q       <= PortInstr;
            lookup_q           <= '0;
            wd_q               <= '0;
            i_done             <= 1'b0;
            d_done             <= 1'b0;
            i_rdata            <= '0;
            d_rdata            <= '0;
            cache_enable       <= 1'b0;
            cache_address      <= '0;
            cache_data_in      <= '0;
            cache_write_enable <= '0;
            err                <= 1'b0;
        end else begin
            state_q            <= state_d;
            owner_q            <= owner_d;
            last_grant_q       <= last_grant_d;
            lookup_q           <= lookup_d;
            wd_q               <= wd_d;
            i_done             <= i_done_d;
            d_done             <= d_done_d;
            i_rdata            <= i_rdata_d;
            d_rdata            <= d_rdata_d;
            cache_enable       <= enable_d;
            cache_address      <= address_d;
            cache_data_in      <= data_in_d;
            cache_write_enable <= write_enable_d;
            err                <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: transaction-timing model plus directed literal checks.
module tb_cache_arbiter;

    localparam int LK = 1;
    localparam int WD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        i_done, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic        cache_enable;
    logic [31:0] cache_address, cache_data_in;
    logic [3:0]  cache_write_enable;
    logic [31:0] cache_data_out;
    logic        cache_data_out_ready, cache_busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.LookupCycles(LK), .WatchdogCycles(WD)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_req                (i_req),
        .i_addr               (i_addr),
        .i_done               (i_done),
        .i_rdata              (i_rdata),
        .d_req                (d_req),
        .d_addr               (d_addr),
        .d_wdata              (d_wdata),
        .d_wstrb              (d_wstrb),
        .d_done               (d_done),
        .d_rdata              (d_rdata),
        .cache_enable         (cache_enable),
        .cache_address        (cache_address),
        .cache_data_in        (cache_data_in),
        .cache_write_enable   (cache_write_enable),
        .cache_data_out       (cache_data_out),
        .cache_data_out_ready (cache_data_out_ready),
        .cache_busy           (cache_busy),
        .err                  (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an access in flight is tracked only by edges elapsed since its grant.
    int          m_phase, m_wd, m_win, m_last;
    logic        m_i_ok, m_d_ok;
    logic        e_i_done, e_d_done, e_en, e_err;
    logic [31:0] e_i_rdata, e_d_rdata, e_addr, e_din;
    logic [3:0]  e_we;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_wd = 0; m_win = 0; m_last = 1;
            e_i_done = 0; e_d_done = 0; e_en = 0; e_err = 0;
            e_i_rdata = 0; e_d_rdata = 0; e_addr = 0; e_din = 0; e_we = 0;
        end else begin
            m_i_ok = i_req && !e_i_done;
            m_d_ok = d_req && !e_d_done;
            e_i_done = 0;
            e_d_done = 0;
            if (m_phase == 0) begin
                if (m_i_ok || m_d_ok) begin
                    if (m_i_ok && m_d_ok)
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
                        m_win = (m_last == 1) ? 2 : 1;
`else
                        m_win = 2;
`endif
                    else
                        m_win = m_d_ok ? 2 : 1;
                    m_last  = m_win;
                    m_phase = 1;
                    m_wd    = 0;
                    e_en    = 1;
                    e_addr  = (m_win == 2) ? d_addr : i_addr;
                    e_din   = (m_win == 2) ? d_wdata : 32'd0;
                    e_we    = (m_win == 2) ? d_wstrb : 4'd0;
                end
            end else begin
                m_phase++;
                if (m_phase >= LK + 2) begin
                    if (cache_busy) begin
                        m_wd++;
                        if (m_wd == WD) e_err = 1;
                    end else if (e_we != 0 || cache_data_out_ready) begin
                        if (e_we == 0) begin
                            if (m_win == 1) e_i_rdata = cache_data_out;
                            else            e_d_rdata = cache_data_out;
                        end
                        if (m_win == 1) e_i_done = 1;
                        else            e_d_done = 1;
                        e_en    = 0;
                        e_we    = 0;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_i_done", {31'd0, i_done}, {31'd0, e_i_done});
        chk("m_d_done", {31'd0, d_done}, {31'd0, e_d_done});
        chk("m_i_rdata", i_rdata, e_i_rdata);
        chk("m_d_rdata", d_rdata, e_d_rdata);
        chk("m_enable", {31'd0, cache_enable}, {31'd0, e_en});
        chk("m_address", cache_address, e_addr);
        chk("m_data_in", cache_data_in, e_din);
        chk("m_write_en", {28'd0, cache_write_enable}, {28'd0, e_we});
        chk("m_err", {31'd0, err}, {31'd0, e_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i_done"}, {31'd0, i_done}, 32'd0);
        chk({tag, "_d_done"}, {31'd0, d_done}, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_enable"}, {31'd0, cache_enable}, 32'd0);
        chk({tag, "_address"}, cache_address, 32'd0);
        chk({tag, "_data_in"}, cache_data_in, 32'd0);
        chk({tag, "_write_en"}, {28'd0, cache_write_enable}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Returns 1 for instruction done, 2 for data done; a timeout is a failed check.
    task automatic wait_done(input int max, output int who);
        who = 0;
        for (int k = 0; k < max; k++) begin
            tick();
            if (d_done) begin who = 2; break; end
            if (i_done) begin who = 1; break; end
        end
        chk("done_within_budget", {31'd0, who != 0}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int who;
        rst_n = 1'b1;
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        cache_data_out = 0; cache_data_out_ready = 0; cache_busy = 0;
        #1 rst_n = 1'b0;
        tick();
        chk_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Instruction hit load, then the re-accept guard with i_req held past i_done.
        cache_data_out_ready = 1; cache_data_out = 32'hDEAD_BEEF;
        i_req = 1; i_addr = 32'h0000_0040;
        tick();
        chk("hit_addr", cache_address, 32'h40);
        chk("hit_enable", {31'd0, cache_enable}, 32'd1);
        tick();
        chk("hit_not_yet", {31'd0, i_done}, 32'd0);
        tick();
        chk("hit_i_done", {31'd0, i_done}, 32'd1);
        chk("hit_i_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("hit_d_done", {31'd0, d_done}, 32'd0);
        tick();
        chk("guard_no_regrant", {31'd0, cache_enable}, 32'd0);
        tick();
        chk("guard_next_grant", {31'd0, cache_enable}, 32'd1);
        i_req = 0;
        wait_done(10, who);
        chk("guard_done_port", who, 32'd1);
        tick();

        // Watchdog: data load with busy over 12 access cycles; err at the 8th.
        cache_data_out = 32'hCAFE_0001;
        d_req = 1; d_addr = 32'h200; d_wstrb = 0; d_wdata = 32'h5555_AAAA;
        tick();
        cache_busy = 1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("wd_err_cycle%0d", k), {31'd0, err}, (k >= 8) ? 32'd1 : 32'd0);
        end
        cache_busy = 0;
        wait_done(4, who);
        chk("wd_done_port", who, 32'd2);
        chk("wd_d_rdata", d_rdata, 32'hCAFE_0001);
        d_req = 0;
        tick(); tick();
        chk("wd_err_sticky", {31'd0, err}, 32'd1);

        // Store with a 20-cycle miss: cache_* held steady, one d_done after busy falls.
        d_req = 1; d_addr = 32'h100; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011; cache_busy = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("st_addr", cache_address, 32'h100);
            chk("st_data", cache_data_in, 32'h1234_5678);
            chk("st_we", {28'd0, cache_write_enable}, 32'h3);
            chk("st_no_done", {31'd0, d_done}, 32'd0);
        end
        cache_busy = 0;
        tick();
        chk("st_d_done", {31'd0, d_done}, 32'd1);
        d_req = 0; d_wstrb = 0;
        tick();
        chk("st_done_once", {31'd0, d_done}, 32'd0);
        chk("st_enable_off", {31'd0, cache_enable}, 32'd0);

        // Asynchronous reset in the middle of a stalled access.
        i_req = 1; i_addr = 32'h300; cache_busy = 1;
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        i_req = 0; cache_busy = 0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_no_done", {31'd0, i_done | d_done}, 32'd0);
        end

        // Collision with both requests held: data wins first, then strict alternation.
        cache_data_out = 32'h0A0B_0C0D;
        i_req = 1; i_addr = 32'h400; d_req = 1; d_addr = 32'h500; d_wstrb = 0;
        tick();
        chk("coll_first_winner", cache_address, 32'h500);
        for (int n = 0; n < 4; n++) begin
            wait_done(12, who);
            chk($sformatf("coll_order%0d", n), who, (n % 2 == 0) ? 32'd2 : 32'd1);
        end
        i_req = 0; d_req = 0;
        chk("coll_rdata", i_rdata, 32'h0A0B_0C0D);
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
